// File: rtl/comp_pkg.sv
// Shared types and default sizing for the compressor front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   loader_state_t   - line loader fill/hold state
//   DATA_WIDTH       - default bits per word
//   WORDS_PER_ENTRY  - default words per cache line
package comp_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    localparam int DATA_WIDTH      = 32;
    localparam int WORDS_PER_ENTRY = 16;

endpackage : comp_pkg

// File: rtl/comp_line_loader.sv
// Packs a 1- or 2-word-per-beat stream into one cache line via the regfile's two write ports.
// Latency: write ports are combinational from the accepted beat; line_valid rises one edge after the last word.
// Backpressure: in_ready drops while a full line waits for line_ack and for the one carry-drain cycle.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready/in_two           input beat handshake; in_two marks in_data1 as valid
//   in_data0, in_data1                 beat words (in_data0 has the lower line index)
//   line_abort                         synchronous discard of the current line, highest priority
//   w_en/word_index/w_data             regfile write port 1
//   w_en2/word_index2/w_data2          regfile write port 2
//   line_valid/line_ack                complete-line handshake towards the compressor
//   word_count                         words written into the current line (registered)
module comp_line_loader #(
    parameter int  DATA_WIDTH      = comp_pkg::DATA_WIDTH,
    parameter int  WORDS_PER_ENTRY = comp_pkg::WORDS_PER_ENTRY,
    localparam int IW              = $clog2(WORDS_PER_ENTRY),
    localparam int CW              = IW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_two,
    input  logic [DATA_WIDTH-1:0] in_data0,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic                  line_abort,

    output logic                  w_en,
    output logic [IW-1:0]         word_index,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_en2,
    output logic [IW-1:0]         word_index2,
    output logic [DATA_WIDTH-1:0] w_data2,

    output logic                  line_valid,
    input  logic                  line_ack,
    output logic [CW-1:0]         word_count
);

    import comp_pkg::*;

    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS_PER_ENTRY - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORDS_PER_ENTRY);

    loader_state_t         state_q,      state_d;
    logic [CW-1:0]         count_q,      count_d;
    logic [DATA_WIDTH-1:0] carry_reg_q,  carry_reg_d;
    logic                  carry_vld_q,  carry_vld_d;
    logic                  line_valid_q, line_valid_d;

    logic accept;     // beat taken this cycle
    logic drain;      // carried word from the previous line's odd split is written this cycle
    logic at_last;    // only one free slot remains in the line
    logic pair_wr;    // both beat words fit in the current line
    logic split;      // second beat word overflows into the next line

    // ------------------------------------------------------------------
    // Handshake and regfile write ports (combinational, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        // rst_n gates the handshake and the write enables directly so that
        // nothing is written or accepted while reset is held low.
        in_ready = rst_n && (state_q == FILL) && !carry_vld_q;
        drain    = rst_n && (state_q == FILL) && carry_vld_q && !line_abort;
        accept   = in_valid && in_ready && !line_abort;
        at_last  = (count_q == LAST_CNT);
        pair_wr  = accept && in_two && !at_last;
        split    = accept && in_two && at_last;

        // Port 1 carries either the drained carry word (always index 0, as
        // the line was just released) or the first word of the beat.
        w_en       = accept || drain;
        word_index = drain ? '0 : count_q[IW-1:0];
        w_data     = drain ? carry_reg_q : in_data0;

        // Port 2 index wraps naturally; the enable is suppressed whenever
        // the wrapped index would alias slot 0 of the line being filled.
        w_en2       = pair_wr;
        word_index2 = count_q[IW-1:0] + IW'(1);
        w_data2     = in_data1;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        carry_reg_d  = carry_reg_q;
        carry_vld_d  = carry_vld_q;
        line_valid_d = line_valid_q;

        if (line_abort) begin
            // Abort beats every other event, including a pending carry.
            state_d      = FILL;
            count_d      = '0;
            carry_vld_d  = 1'b0;
            line_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (carry_vld_q) begin
                        count_d     = CW'(1);
                        carry_vld_d = 1'b0;
                    end else if (accept) begin
                        count_d = count_q + CW'(1) + CW'(pair_wr);
                        if (split) begin
                            carry_reg_d = in_data1;
                            carry_vld_d = 1'b1;
                        end
                        if (count_d == FULL_CNT) begin
                            state_d      = FULL;
                            line_valid_d = 1'b1;
                        end
                    end
                end
                FULL: begin
                    // A pending carry survives the ack and drains next cycle.
                    if (line_ack) begin
                        state_d      = FILL;
                        count_d      = '0;
                        line_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            count_q      <= '0;
            carry_reg_q  <= '0;
            carry_vld_q  <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            carry_reg_q  <= carry_reg_d;
            carry_vld_q  <= carry_vld_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign line_valid = line_valid_q;
    assign word_count = count_q;

endmodule : comp_line_loader

// File: tb/tb_comp_line_loader.sv
// Self-checking bench for comp_line_loader with a queue-based line model and a regfile shadow.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_comp_line_loader;

    localparam int DW = 32;
    localparam int WORDS = 16;
    localparam int IW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_two, line_abort, line_ack;
    logic [DW-1:0] in_data0, in_data1;
    logic          w_en, w_en2, line_valid;
    logic [IW-1:0] word_index, word_index2;
    logic [DW-1:0] w_data, w_data2;
    logic [CW-1:0] word_count;

    comp_line_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_two      (in_two),
        .in_data0    (in_data0),
        .in_data1    (in_data1),
        .line_abort  (line_abort),
        .w_en        (w_en),
        .word_index  (word_index),
        .w_data      (w_data),
        .w_en2       (w_en2),
        .word_index2 (word_index2),
        .w_data2     (w_data2),
        .line_valid  (line_valid),
        .line_ack    (line_ack),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    // Shadow of the line register file, written from the DUT's ports.
    logic [DW-1:0] mem [WORDS];
    always @(posedge clk) begin
        if (w_en)  mem[word_index]  <= w_data;
        if (w_en2) mem[word_index2] <= w_data2;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: the line as a queue of words ----------------
    logic [DW-1:0] m_line[$];
    logic [DW-1:0] m_carry[$];
    bit            m_full;

    task automatic model_clear();
        m_line.delete();
        m_carry.delete();
        m_full = 0;
    endtask

    // Drive one cycle: inputs applied just after a rising edge, outputs checked
    // mid-cycle against the model, then the model advances on the edge.
    task automatic step(input logic v, input logic t, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic ab, input logic ak);
        bit            e_rdy, e_wen, e_wen2, became_full;
        logic [IW-1:0] e_idx, e_idx2;
        logic [DW-1:0] e_dat;
        logic [WORDS*DW-1:0] got_line, exp_line;
        in_valid = v; in_two = t; in_data0 = a; in_data1 = b;
        line_abort = ab; line_ack = ak;
        #3;
        e_rdy  = !m_full && (m_carry.size() == 0);
        e_wen  = 0; e_wen2 = 0; e_idx = '0; e_idx2 = '0; e_dat = '0;
        if (!ab) begin
            if (!m_full && m_carry.size() != 0) begin
                e_wen = 1; e_idx = '0; e_dat = m_carry[0];
            end else if (e_rdy && v) begin
                e_wen = 1; e_idx = IW'(m_line.size()); e_dat = a;
                if (t && m_line.size() < WORDS - 1) begin
                    e_wen2 = 1; e_idx2 = IW'(m_line.size() + 1);
                end
            end
        end
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("w_en", 64'(w_en), 64'(e_wen));
        chk("w_en2", 64'(w_en2), 64'(e_wen2));
        chk("line_valid", 64'(line_valid), 64'(m_full));
        chk("word_count", 64'(word_count), 64'(m_line.size()));
        if (e_wen) begin
            chk("word_index", 64'(word_index), 64'(e_idx));
            chk("w_data", 64'(w_data), 64'(e_dat));
        end
        if (e_wen2) begin
            chk("word_index2", 64'(word_index2), 64'(e_idx2));
            chk("w_data2", 64'(w_data2), 64'(b));
        end
        @(posedge clk);
        became_full = 0;
        if (ab) begin
            model_clear();
        end else if (m_full) begin
            if (ak) begin
                m_line.delete();
                m_full = 0;
            end
        end else if (m_carry.size() != 0) begin
            m_line.push_back(m_carry.pop_front());
        end else if (v) begin
            m_line.push_back(a);
            if (t) begin
                if (m_line.size() < WORDS) m_line.push_back(b);
                else m_carry.push_back(b);
            end
            if (m_line.size() == WORDS) begin
                m_full = 1;
                became_full = 1;
            end
        end
        #1;
        if (became_full) begin
            for (int i = 0; i < WORDS; i++) begin
                got_line[i*DW +: DW] = mem[i];
                exp_line[i*DW +: DW] = m_line[i];
            end
            n_checks++;
            if (got_line !== exp_line) begin
                n_errors++;
                $display("FAIL line_contents got=%0h expected=%0h", got_line, exp_line);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 0; in_two = 0; in_data0 = '0; in_data1 = '0;
        line_abort = 0; line_ack = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic v, t, ab, ak;
        logic [DW-1:0] d0, d1;
        logic e_rdy, e_wen, e_wen2, e_lv;
        logic [IW-1:0] e_idx, e_idx2;
        logic [CW-1:0] e_wc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        //          v  t  ab ak d0        d1        rdy wen wen2 lv idx idx2 wc
        tbl[0] = '{1, 1, 0, 0, 32'hA0,  32'hA1,  1,  1,  1,  0,  0,  1,  0};
        tbl[1] = '{1, 0, 0, 0, 32'hB0,  32'hB1,  1,  1,  0,  0,  2,  3,  2};
        tbl[2] = '{0, 0, 0, 0, 32'h0,   32'h0,   1,  0,  0,  0,  3,  4,  3};
        tbl[3] = '{1, 1, 1, 0, 32'hC0,  32'hC1,  1,  0,  0,  0,  3,  4,  3};
        tbl[4] = '{1, 1, 0, 0, 32'hD0,  32'hD1,  1,  1,  1,  0,  0,  1,  0};
        tbl[5] = '{0, 0, 0, 1, 32'h0,   32'h0,   1,  0,  0,  0,  2,  3,  2};
        tbl[6] = '{1, 0, 0, 0, 32'hE0,  32'hE1,  1,  1,  0,  0,  2,  3,  2};
        tbl[7] = '{0, 0, 0, 0, 32'h0,   32'h0,   1,  0,  0,  0,  3,  4,  3};

        // Reset state, observed while reset is asserted with a beat offered.
        rst_n = 1'b0;
        in_valid = 1; in_two = 1; in_data0 = '0; in_data1 = '0;
        line_abort = 0; line_ack = 0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_w_en", 64'(w_en), 64'd0);
        chk("rst_w_en2", 64'(w_en2), 64'd0);
        chk("rst_line_valid", 64'(line_valid), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; in_two = tbl[i].t; line_abort = tbl[i].ab;
            line_ack = tbl[i].ak; in_data0 = tbl[i].d0; in_data1 = tbl[i].d1;
            #3;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_w_en", i), 64'(w_en), 64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_w_en2", i), 64'(w_en2), 64'(tbl[i].e_wen2));
            chk($sformatf("tbl%0d_word_index", i), 64'(word_index), 64'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_word_index2", i), 64'(word_index2), 64'(tbl[i].e_idx2));
            chk($sformatf("tbl%0d_line_valid", i), 64'(line_valid), 64'(tbl[i].e_lv));
            chk($sformatf("tbl%0d_word_count", i), 64'(word_count), 64'(tbl[i].e_wc));
            if (tbl[i].e_wen) chk($sformatf("tbl%0d_w_data", i), 64'(w_data), 64'(tbl[i].d0));
            if (tbl[i].e_wen2) chk($sformatf("tbl%0d_w_data2", i), 64'(w_data2), 64'(tbl[i].d1));
            @(posedge clk);
            #1;
        end

        // Eight two-word beats: words 0..15, line_valid the cycle after beat 8.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, DW'(2*i), DW'(2*i+1), 0, 0);
        chk("pairs_line_valid", 64'(line_valid), 64'd1);
        chk("pairs_word_count", 64'(word_count), 64'(WORDS));
        step(0, 0, '0, '0, 0, 1);

        // Sixteen single-word beats; port 2 must stay idle.
        for (int i = 0; i < 16; i++) begin
            step(1, 0, DW'(32'h100 + i), DW'(32'hDEAD), 0, 0);
            if (i == 14) chk("single_not_yet_valid", 64'(line_valid), 64'd0);
        end
        chk("single_line_valid", 64'(line_valid), 64'd1);
        step(0, 0, '0, '0, 0, 1);

        // Odd split: 7 pairs, 1 single, then {A,B}.
        for (int i = 0; i < 7; i++) step(1, 1, DW'(32'h200 + 2*i), DW'(32'h201 + 2*i), 0, 0);
        step(1, 0, DW'(32'h20E), '0, 0, 0);
        chk("split_count15", 64'(word_count), 64'd15);
        step(1, 1, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0);
        chk("split_a_at_15", 64'(mem[15]), 64'hAAAA_0001);
        chk("split_line_valid", 64'(line_valid), 64'd1);
        step(0, 0, '0, '0, 0, 1);
        chk("drain_in_ready_low", 64'(in_ready), 64'd0);
        chk("drain_w_en", 64'(w_en), 64'd1);
        chk("drain_w_data", 64'(w_data), 64'hBBBB_0002);
        idle();
        chk("drain_b_at_0", 64'(mem[0]), 64'hBBBB_0002);
        chk("drain_word_count", 64'(word_count), 64'd1);
        chk("drain_in_ready_back", 64'(in_ready), 64'd1);

        // Finish that line (15 more words), then hold with no ack for 10 cycles.
        for (int i = 0; i < 7; i++) step(1, 1, DW'(32'h300 + 2*i), DW'(32'h301 + 2*i), 0, 0);
        step(1, 0, DW'(32'h30E), '0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, DW'(32'h400 + i), DW'(32'h500 + i), 0, 0);
            chk("hold_line_valid", 64'(line_valid), 64'd1);
        end
        step(1, 1, DW'(32'h600), DW'(32'h601), 0, 1);
        chk("ack_in_ready", 64'(in_ready), 64'd1);

        // Abort at count=6 together with in_valid.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, DW'(32'h700 + i), DW'(32'h710 + i), 0, 0);
        step(1, 1, 32'h777, 32'h778, 1, 0);
        chk("abort_word_count", 64'(word_count), 64'd0);

        // Abort in FULL with a carry pending.
        for (int i = 0; i < 7; i++) step(1, 1, DW'(32'h800 + i), DW'(32'h810 + i), 0, 0);
        step(1, 0, 32'h820, '0, 0, 0);
        step(1, 1, 32'h830, 32'h831, 0, 0);
        step(1, 1, 32'h840, 32'h841, 1, 0);
        in_valid = 0;
        #1;
        chk("abort_full_line_valid", 64'(line_valid), 64'd0);
        chk("abort_full_no_drain", 64'(w_en), 64'd0);
        chk("abort_full_in_ready", 64'(in_ready), 64'd1);
        idle();

        // Reset dropped mid-fill at count=9.
        for (int i = 0; i < 4; i++) step(1, 1, DW'(32'h900 + i), DW'(32'h910 + i), 0, 0);
        step(1, 0, 32'h920, '0, 0, 0);
        chk("pre_reset_count9", 64'(word_count), 64'd9);
        in_valid = 1; in_two = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_w_en", 64'(w_en), 64'd0);
        chk("midrst_line_valid", 64'(line_valid), 64'd0);
        chk("midrst_word_count", 64'(word_count), 64'd0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, DW'(32'hA00 + i), DW'(32'hB00 + i), 0, 0);
        chk("post_reset_line_valid", 64'(line_valid), 64'd1);
        step(0, 0, '0, '0, 0, 1);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 1'($urandom), $urandom, $urandom,
                 ($urandom % 50) == 0, ($urandom % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_comp_line_loader
